pif_ram_arbiter: RTL
====================

PIF_RAM_ARBITER -- requirements
Module: pif_ram_arbiter

Interface
REQ-001 SHALL have parameter WP_LIMIT, default 9'd448: requester-A addresses below this are the protected boot region.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports a_req in 1, a_we in 1, a_addr in 9, a_wdata in 8: requester A (console/SI side) request, write-enable, address, write data.
REQ-005 SHALL have ports a_ack out 1, a_rdata out 8, a_err out 1: requester A completion pulse, read data, protection-violation flag.
REQ-006 SHALL have ports b_req in 1, b_we in 1, b_addr in 9, b_wdata in 8, b_ack out 1, b_rdata out 8: requester B (PIF CPU side), same meaning, no protection.
REQ-007 SHALL have port rom_lock  in  1  when high, A reads below WP_LIMIT are also blocked.
REQ-008 SHALL have ports ram_address out 9, ram_we out 1, ram_data out 8, ram_oe out 1: registered drive to the PIF RAM.
REQ-009 SHALL have ports ram_q in 8, ram_valid in 1: RAM read data and valid, one cycle after ram_address/ram_oe are presented.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP; exactly one access in flight.
REQ-011 IDLE: if any req high, SHALL select a winner, latch its we/addr/wdata, register RAM outputs, go to ACCESS; else stay IDLE with ram_we=0, ram_oe=0.
REQ-012 Arbitration SHALL be round-robin: pointer starts at A; on simultaneous a_req and b_req, pointer side wins; pointer then flips to the loser.
REQ-013 Single requester SHALL win regardless of pointer; pointer SHALL flip to the other requester after each grant.
REQ-014 ACCESS: ram_address/ram_data/ram_we/ram_oe SHALL hold latched values for exactly this one cycle; ram_oe=1 for reads and writes; next state RESP.
REQ-015 RESP: SHALL drive winner's ack=1 for exactly one cycle, rdata=ram_q for reads (rdata=8'h00 for writes), deassert ram_we/ram_oe, return to IDLE.
REQ-016 Latency SHALL be fixed: req sampled in IDLE at edge N, ack high in cycle N+2 (counting IDLE as N); back-to-back accesses every 3 cycles.
REQ-017 rdata SHALL hold last returned value until next ack to that requester; ack of the non-winner SHALL stay 0.
REQ-018 If ram_valid is 0 in RESP for a read, rdata SHALL be 8'h00 (ack still issued).
REQ-019 Requester SHALL keep req/we/addr/wdata stable until ack; req still high in cycle after ack SHALL be treated as a new request.
REQ-020 A write with a_addr < WP_LIMIT SHALL be suppressed: ram_we=0 and ram_oe=0 in ACCESS, a_ack still pulses in RESP with a_err=1.
REQ-021 A read with a_addr < WP_LIMIT while rom_lock=1 (sampled at grant) SHALL issue ram_oe=0, return a_rdata=8'h00, a_err=1.
REQ-022 a_err SHALL be valid only with a_ack, 0 otherwise; B accesses SHALL never be blocked.
REQ-023 Changes on rom_lock after grant SHALL not affect the in-flight access.
REQ-024 Addresses SHALL be 9-bit with no wrap logic; 9'h1FF is a valid last location.

Reset
REQ-025 On reset assert, asynchronously: state=IDLE, pointer=A, a_ack=b_ack=a_err=0, a_rdata=b_rdata=8'h00, ram_address=0, ram_data=0, ram_we=0, ram_oe=0.
REQ-026 Reset mid-ACCESS or mid-RESP SHALL abort the access with no ack; a pending write in ACCESS at reset SHALL not be completed by the arbiter.
REQ-027 First request after reset release SHALL be sampled at the first rising edge with reset low.

Verification
REQ-028 B write 9'h1C5<=8'hA5, then A read 9'h1C5 -> ram_we pulse 1 cycle, b_ack at N+2; a_rdata=8'hA5, a_err=0, a_ack at N+2.
REQ-029 a_req and b_req high together continuously from reset -> grants A,B,A,B, one ack every 3 cycles, never two acks in one cycle.
REQ-030 A write 9'h010<=8'h55 -> ram_we stays 0, a_ack with a_err=1; B read 9'h010 returns prior content unchanged.
REQ-031 rom_lock=1, A read 9'h000 -> ram_oe=0, a_rdata=8'h00, a_err=1; rom_lock=0 repeat -> RAM data returned, a_err=0.
REQ-032 Reset pulsed during ACCESS of a B write -> no b_ack, all outputs zero, next a_req granted to A first.

Source files
------------

// File: rtl/pif_ram_arbiter.sv
// pif_ram_arbiter
// Two-requester arbiter in front of the single-port PIF RAM. Requester A is the
// console/SI side and may not write below WP_LIMIT. When rom_lock is high it may
// not read there either. Requester B is the PIF CPU side and is never blocked.
// Only one access is in flight at a time: IDLE -> ACCESS -> RESP. The ack comes
// two cycles after the request is sampled in IDLE.
//
// Ports
//   clk, reset                   clock; asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata    requester A command (held stable until a_ack)
//   a_ack/a_rdata/a_err          requester A one-cycle completion, read data, violation
//   b_req/b_we/b_addr/b_wdata    requester B command (held stable until b_ack)
//   b_ack/b_rdata                requester B completion and read data
//   rom_lock                     also blocks A reads below WP_LIMIT; sampled at grant
//   ram_address/ram_we/ram_data/ram_oe  registered RAM drive
//   ram_q/ram_valid              RAM read return, one cycle after ram_oe
module pif_ram_arbiter #(
  parameter logic [8:0] WP_LIMIT = 9'd448
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [8:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  output logic       a_err,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [8:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  input  logic       rom_lock,
  output logic [8:0] ram_address,
  output logic       ram_we,
  output logic [7:0] ram_data,
  output logic       ram_oe,
  input  logic [7:0] ram_q,
  input  logic       ram_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state;
  logic       ptr;       // round-robin priority: 0 = A, 1 = B
  logic       win;       // owner of the in-flight access: 0 = A, 1 = B
  logic       we_l;      // in-flight access is a write
  logic       blk;       // in-flight access was suppressed by protection
  logic [7:0] a_rdata_q;
  logic [7:0] b_rdata_q;

  // Grant selection, only acted on in IDLE.
  logic       grant;
  logic       pick_b;
  logic       sel_we;
  logic [8:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       sel_blk;

  always_comb begin
    grant     = a_req | b_req;
    // B wins if it is alone, or if both request and the pointer favours B.
    pick_b    = b_req & (~a_req | ptr);
    sel_we    = pick_b ? b_we : a_we;
    sel_addr  = pick_b ? b_addr : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    // Writes below the limit are always blocked for A; reads only under rom_lock.
    sel_blk   = ~pick_b & (a_addr < WP_LIMIT) & (a_we | rom_lock);
  end

  // Response data: writes and blocked or invalid reads return zero.
  logic       resp_rd;
  logic [7:0] resp_data;
  logic       in_resp;

  always_comb begin
    in_resp   = (state == RESP);
    resp_rd   = ~we_l & ~blk & ram_valid;
    resp_data = resp_rd ? ram_q : 8'h00;
  end

  // The ack, err and fresh read data are driven combinationally in RESP, since
  // ram_q only arrives in that cycle. The rdata registers keep the value afterwards.
  always_comb begin
    a_ack   = in_resp & ~win;
    b_ack   = in_resp & win;
    a_err   = a_ack & blk;
    a_rdata = a_ack ? resp_data : a_rdata_q;
    b_rdata = b_ack ? resp_data : b_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      win         <= 1'b0;
      we_l        <= 1'b0;
      blk         <= 1'b0;
      a_rdata_q   <= 8'h00;
      b_rdata_q   <= 8'h00;
      ram_address <= 9'h000;
      ram_data    <= 8'h00;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state       <= ACCESS;
            win         <= pick_b;
            ptr         <= ~pick_b;
            we_l        <= sel_we;
            blk         <= sel_blk;
            ram_address <= sel_addr;
            ram_data    <= sel_wdata;
            ram_we      <= sel_we & ~sel_blk;
            ram_oe      <= ~sel_blk;
          end else begin
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
          end
        end
        ACCESS: begin
          // The RAM strobes are held for just this cycle.
          state  <= RESP;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          if (win) begin
            b_rdata_q <= resp_data;
          end else begin
            a_rdata_q <= resp_data;
          end
        end
        default: begin
          state  <= IDLE;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
